// File: rtl/pc_pkg.sv
// Shared types for the next-PC unit: control FSM states and next-PC mux selects.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fsm_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_HOLD,
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR,
        SEL_RAS
    } pc_sel_t;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// push and pop together replace the top entry in place. Pop when empty is ignored.
module ret_addr_stack #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty,
    output logic        full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // ptr is the next free slot; the top entry sits just below it
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] top_idx;
    logic          do_pop;

    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;

    // Pointer, occupancy and storage update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push && do_pop) begin
            mem[top_idx] <= push_data;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (do_pop) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC generator: boot/run/halt control FSM, target adders and priority mux.
// Define RAS_EN to add a return-address stack for call/ret; without it ret acts as jr.
module next_pc_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        call,
    input  logic        ret,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] next_pc,
    output logic [1:0]  fsm_state,
    output logic        ras_miss
);

    fsm_state_t  state_q, state_d;
    pc_sel_t     sel;
    logic [31:0] pc4, branch_tgt, jump_tgt;
    logic        active;
    logic        ras_empty;
    logic [31:0] ras_top;
    logic        miss_d, miss_q;

    assign pc4        = pc_in + INSTR_BYTES;
    assign branch_tgt = pc4 + (branch_offset << 2);
    assign jump_tgt   = {pc4[31:28], jump_index, 2'b00};

    // A cycle in which the instruction's redirect/link actually takes effect
    assign active = (state_q == RUN) && !halt_req && !stall;

`ifdef RAS_EN
    logic unused_ras_full;

    ret_addr_stack #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (active && call),
        .pop      (active && ret),
        .push_data(pc4),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (unused_ras_full)
    );

    assign miss_d = active && ret && ras_empty;
`else
    logic        unused_call;
    logic [31:0] unused_depth;

    assign unused_call  = call;
    assign unused_depth = 32'(RAS_DEPTH);
    // Permanently empty stack makes ret fall back to jr_target
    assign ras_empty    = 1'b1;
    assign ras_top      = jr_target;
    assign miss_d       = 1'b0;
`endif

    // Select the next-PC source by state, then by redirect priority
    always_comb begin
        sel = SEL_SEQ;
        unique case (state_q)
            BOOT: sel = SEL_RESET;
            HALT: sel = SEL_HOLD;
            RUN: begin
                if (halt_req || stall) sel = SEL_HOLD;
                else if (ret)          sel = ras_empty ? SEL_JR : SEL_RAS;
                else if (jr)           sel = SEL_JR;
                else if (jump)         sel = SEL_JUMP;
                else if (branch_taken) sel = SEL_BRANCH;
                else                   sel = SEL_SEQ;
            end
            default: sel = SEL_RESET;
        endcase
    end

    // Next-PC mux
    always_comb begin
        next_pc = RESET_VECTOR;
        unique case (sel)
            SEL_RESET:  next_pc = RESET_VECTOR;
            SEL_HOLD:   next_pc = pc_in;
            SEL_SEQ:    next_pc = pc4;
            SEL_BRANCH: next_pc = branch_tgt;
            SEL_JUMP:   next_pc = jump_tgt;
            SEL_JR:     next_pc = jr_target;
            SEL_RAS:    next_pc = ras_top;
            default:    next_pc = RESET_VECTOR;
        endcase
    end

    // Control FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_req) state_d = HALT;
            HALT:    if (resume) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // State and miss-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    assign fsm_state = state_q;
    assign ras_miss  = miss_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed steps followed by random stimulus,
// all checked against a queue-based reference model. RAS checks apply when RAS_EN is defined.
module tb_next_pc_unit;

    localparam logic [31:0] RV    = 32'hBFC0_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        call;
    logic        ret;
    logic        halt_req;
    logic        resume;
    logic [31:0] next_pc;
    logic [1:0]  fsm_state;
    logic        ras_miss;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: 0=boot 1=run 2=halt; RAS as a bounded queue
    int          m_state;
    logic [31:0] m_ras[$];
    logic        m_miss;

    next_pc_unit #(
        .RESET_VECTOR(RV),
        .RAS_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_in        (pc_in),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_target    (jr_target),
        .call         (call),
        .ret          (ret),
        .halt_req     (halt_req),
        .resume       (resume),
        .next_pc      (next_pc),
        .fsm_state    (fsm_state),
        .ras_miss     (ras_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

`ifdef RAS_EN
    localparam bit HAS_RAS = 1'b1;
`else
    localparam bit HAS_RAS = 1'b0;
`endif

    function automatic logic [31:0] model_pc();
        logic [31:0] p4;
        p4 = pc_in + 32'd4;
        if (m_state == 0) return RV;
        if (m_state == 2) return pc_in;
        if (halt_req || stall) return pc_in;
        if (ret) return (HAS_RAS && m_ras.size() > 0) ? m_ras[$] : jr_target;
        if (jr) return jr_target;
        if (jump) return {p4[31:28], jump_index, 2'b00};
        if (branch_taken) return p4 + branch_offset * 32'd4;
        return p4;
    endfunction

    task automatic model_step();
        bit eff;
        eff    = (m_state == 1) && !halt_req && !stall;
        m_miss = HAS_RAS && eff && ret && (m_ras.size() == 0);
        if (HAS_RAS && eff) begin
            if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
            if (call) begin
                m_ras.push_back(pc_in + 32'd4);
                if (m_ras.size() > DEPTH) m_ras.delete(0);
            end
        end
        if (m_state == 0) m_state = 1;
        else if (m_state == 1 && halt_req) m_state = 2;
        else if (m_state == 2 && resume) m_state = 1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_miss  = 1'b0;
        m_ras.delete();
    endtask

    // Check outputs mid-cycle against the model, then advance past the next edge
    task automatic tick(input string tag);
        @(negedge clk);
        chk({tag, ".pc"}, next_pc, model_pc());
        chk({tag, ".st"}, 32'(fsm_state), 32'(m_state));
        chk({tag, ".miss"}, 32'(ras_miss), 32'(m_miss));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; jump = 0; jr = 0; call = 0; ret = 0;
        halt_req = 0; resume = 0; branch_offset = 0; jump_index = 0; jr_target = 0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ras_exp[4];
        idle();
        rst_n = 0;
        pc_in = 32'h40;
        model_reset();
        #2;
        chk("rst.st", 32'(fsm_state), 32'd0);
        chk("rst.pc", next_pc, RV);
        chk("rst.miss", 32'(ras_miss), 32'd0);

        @(posedge clk); #1;
        rst_n = 1;
        #1 chk("boot.pc", next_pc, RV);
        tick("boot");
        chk("run.st", 32'(fsm_state), 32'd1);
        chk("run.pc", next_pc, 32'h44);
        tick("seq");

        pc_in = 32'h100; branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
        #1 chk("branch", next_pc, 32'hFC);
        tick("branch");
        stall = 1;
        #1 chk("stall", next_pc, 32'h100);
        tick("stall");
        idle();

        pc_in = 32'h3000_0010; jump = 1; jump_index = 26'h40;
        #1 chk("jump", next_pc, 32'h3000_0100);
        tick("jump");
        idle();
        pc_in = 32'hFFFF_FFFC;
        #1 chk("wrap", next_pc, 32'h0);
        tick("wrap");
        pc_in = 32'h500; jr = 1; jr_target = 32'h1234; jump = 1;
        #1 chk("jr", next_pc, 32'h1234);
        tick("jr");
        idle();

        pc_in = 32'h200; halt_req = 1;
        #1 chk("halt.pc", next_pc, 32'h200);
        tick("halt");
        chk("halt.st", 32'(fsm_state), 32'd2);
        halt_req = 0; branch_taken = 1; branch_offset = 32'h10;
        for (int i = 0; i < 5; i++) begin
            chk("halt.hold", next_pc, 32'h200);
            tick("halt.hold");
        end
        resume = 1;
        tick("resume");
        chk("resume.st", 32'(fsm_state), 32'd1);
        idle();

`ifdef RAS_EN
        for (int i = 0; i < 5; i++) begin
            pc_in = 32'(16 * (i + 1)); call = 1; jump = 1; jump_index = 26'h100;
            tick("call");
        end
        idle();
        ras_exp[0] = 32'h54; ras_exp[1] = 32'h44; ras_exp[2] = 32'h34; ras_exp[3] = 32'h24;
        pc_in = 32'h800; ret = 1; jr_target = 32'h99;
        for (int i = 0; i < 4; i++) begin
            #1 chk("ret", next_pc, ras_exp[i]);
            tick("ret");
            chk("ret.nomiss", 32'(ras_miss), 32'd0);
        end
        #1 chk("ret.empty", next_pc, 32'h99);
        tick("ret.empty");
        chk("ret.miss", 32'(ras_miss), 32'd1);
        idle();
        tick("miss.drop");
`endif

        // Load the RAS, then reset between edges
        pc_in = 32'h600; call = 1;
        tick("precall");
        idle();
        #2 rst_n = 0;
        #1;
        chk("arst.st", 32'(fsm_state), 32'd0);
        chk("arst.pc", next_pc, RV);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        tick("arst.boot");
        pc_in = 32'h300; ret = 1; jr_target = 32'h77;
        #1 chk("arst.ret", next_pc, 32'h77);
        tick("arst.ret");
        idle();
        tick("arst.after");

        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            pc_in         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {r[31:2], 2'b00};
            halt_req      = ($urandom_range(0, 15) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            stall         = ($urandom_range(0, 7) == 0);
            ret           = ($urandom_range(0, 4) == 0);
            call          = ($urandom_range(0, 3) == 0);
            jr            = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 4) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_offset = $urandom();
            r             = $urandom();
            jump_index    = r[25:0];
            jr_target     = $urandom();
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
